t08_mem_responder: RTL

T08_MEM_RESPONDER -- requirements
Module: t08_mem_responder

---
 rtl/t08_mem_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/t08_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : t08_mem_responder
// Brief    : Memory-mapped responder with word RAM, I2C receive word and SPI
//            command register behind a fixed-latency request handshake.
// Revision : 1.0 - initial release
// ============================================================================
module t08_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [31:0] i2c_data,
    input  logic        i2c_valid,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [31:0] spi_cmd,
    output logic        spi_start
);

    localparam int          AW            = $clog2(DEPTH);
    localparam logic [31:0] I2C_ADDRESS   = 32'd923923;
    localparam logic [31:0] SPI_ADDRESS_C = 32'd121212;
    localparam logic [3:0]  LAT_LOAD      = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        I2CWAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [31:0] spi_cmd_q, spi_cmd_d;
    logic        spi_start_q, spi_start_d;

    logic [31:0] mem [DEPTH];
    logic        mem_we;
    logic [AW-1:0] word_idx;
    logic        ram_hit;

    // Decode uses the latched address so late changes on the bus are harmless.
    assign word_idx = addr_q[AW+1:2];
    assign ram_hit  = (addr_q[31:AW+2] == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        spi_cmd_d   = spi_cmd_q;
        spi_start_d = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (read || write) begin
                    addr_d  = address;
                    wdata_d = wdata;
                    wr_d    = write;
                    busy_d  = 1'b1;
                    if (!write && (address == I2C_ADDRESS)) begin
                        state_d = I2CWAIT;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end

            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    if (wr_q) begin
                        if (ram_hit) begin
                            mem_we = 1'b1;
                        end else if (addr_q == SPI_ADDRESS_C) begin
                            spi_cmd_d   = wdata_q;
                            spi_start_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (ram_hit) begin
                        rdata_d = mem[word_idx];
                    end else begin
                        // I2C reads never reach WAIT, so any other read is unmapped.
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            I2CWAIT: begin
                if (i2c_valid) begin
                    rdata_d = i2c_data;
                    done_d  = 1'b1;
                    state_d = RESP;
                end
            end

            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wr_q        <= 1'b0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            spi_cmd_q   <= 32'd0;
            spi_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            spi_cmd_q   <= spi_cmd_d;
            spi_start_q <= spi_start_d;
        end
    end

    // RAM contents survive reset; mem_we is only raised from WAIT, never in reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wdata_q;
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign spi_cmd   = spi_cmd_q;
    assign spi_start = spi_start_q;

endmodule
`default_nettype wire
